pipe_stage_fifo: RTL and testbench

- Parametrised elastic pipeline register that generalises the single-entry valid/ready stage register.
- Holds up to DEPTH entries of DATA_W bits in FIFO order, with a selectable ready mode: combinational pass-through, or fully registered ready to cut the ready timing path.
- Supports single-cycle flush.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...), carrying instruction, PC and sideband bits packed into one data bus.

---
 rtl/pipe_stage_fifo.sv | 73 +++++++
 tb/tb_pipe_stage_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// Elastic valid/ready pipeline register holding up to DEPTH entries in FIFO order.
// REG_READY selects a pass-through or fully registered in_ready.
module pipe_stage_fifo #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned REG_READY = 0,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              accept;
  logic              send;

  // Explicit wrap at DEPTH-1 since DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign in_ready  = (REG_READY != 0) ? ~full : (~full | out_ready);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign count_o   = count;
  assign accept    = in_valid & in_ready;
  assign send      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= bump(wr_ptr);
      if (send)   rd_ptr <= bump(rd_ptr);
      case ({accept, send})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // At full with REG_READY=0, wr_ptr == rd_ptr, so the write refills the slot being read.
  always_ff @(posedge clk) begin
    if (accept && !flush_i && !reset) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (count <= CNT_W'(DEPTH));
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo across three configurations sharing one stimulus bus.
module tb_pipe_stage_fifo;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset, flush_i, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic          rdy2, vld2, rdy3, vld3, rdy4, vld4;
  logic [DW-1:0] dat2, dat3, dat4;
  logic [1:0]    cnt2, cnt3;
  logic [2:0]    cnt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_fifo #(.DATA_W(DW), .DEPTH(2), .REG_READY(0)) u_d2 (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .out_valid(vld2), .out_ready(out_ready), .out_data(dat2), .count_o(cnt2));

  pipe_stage_fifo #(.DATA_W(DW), .DEPTH(3), .REG_READY(1)) u_d3 (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid(in_valid), .in_ready(rdy3),
    .in_data(in_data), .out_valid(vld3), .out_ready(out_ready), .out_data(dat3), .count_o(cnt3));

  pipe_stage_fifo #(.DATA_W(DW), .DEPTH(4), .REG_READY(0)) u_d4 (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .out_valid(vld4), .out_ready(out_ready), .out_data(dat4), .count_o(cnt4));

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (vld2 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", vld2); end
    total++; if (rdy2 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", rdy2); end
    total++; if (cnt2 !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", cnt2); end
    tick();
    tick();
    in_valid = 1'b1; in_data = 16'h000A;
    #1;
    total++; if (vld2 !== 1'b0) begin bad++; $display("FAIL no_fallthrough got=%b exp=0", vld2); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (vld2 !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", vld2); end
    total++; if (dat2 !== 16'h000A) begin bad++; $display("FAIL first_data got=%0h exp=a", dat2); end
    total++; if (cnt2 !== 2'd1) begin bad++; $display("FAIL first_count got=%0d exp=1", cnt2); end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      #1;
      total++; if (rdy3 !== 1'b1) begin bad++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, rdy3); end
      if (i > 1) begin
        total++; if (vld3 !== 1'b1 || dat3 !== DW'(i - 1))
          begin bad++; $display("FAIL stream_data i=%0d got=%b/%0d exp=1/%0d", i, vld3, dat3, i - 1); end
        total++; if (cnt3 !== 2'd1) begin bad++; $display("FAIL stream_count i=%0d got=%0d exp=1", i, cnt3); end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    total++; if (vld3 !== 1'b1 || dat3 !== 16'd20) begin bad++; $display("FAIL stream_last got=%b/%0d exp=1/20", vld3, dat3); end
    tick();
    #1;
    total++; if (vld3 !== 1'b0 || cnt3 !== 2'd0) begin bad++; $display("FAIL stream_empty got=%b/%0d exp=0/0", vld3, cnt3); end
  endtask

  task automatic test_backpressure_wrap();
    logic [DW-1:0] exp_q [3];
    exp_q = '{16'd2, 16'd3, 16'd4};
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      #1;
      total++; if (rdy3 !== 1'b1) begin bad++; $display("FAIL bp_in_ready i=%0d got=%b exp=1", i, rdy3); end
      tick();
      total++; if (dat3 !== 16'd1) begin bad++; $display("FAIL bp_stall_data i=%0d got=%0d exp=1", i, dat3); end
    end
    in_valid = 1'b0;
    #1;
    total++; if (cnt3 !== 2'd3) begin bad++; $display("FAIL bp_full_count got=%0d exp=3", cnt3); end
    total++; if (rdy3 !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", rdy3); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'd99;
    #1;
    total++; if (rdy3 !== 1'b0) begin bad++; $display("FAIL bp_regready got=%b exp=0", rdy3); end
    total++; if (dat3 !== 16'd1) begin bad++; $display("FAIL bp_pop1 got=%0d exp=1", dat3); end
    tick();
    out_ready = 1'b0; in_data = 16'd4;
    #1;
    total++; if (cnt3 !== 2'd2 || rdy3 !== 1'b1) begin bad++; $display("FAIL bp_after_pop got=%0d/%b exp=2/1", cnt3, rdy3); end
    total++; if (dat3 !== 16'd2) begin bad++; $display("FAIL bp_head2 got=%0d exp=2", dat3); end
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (vld3 !== 1'b1 || dat3 !== exp_q[k])
        begin bad++; $display("FAIL bp_drain k=%0d got=%b/%0d exp=1/%0d", k, vld3, dat3, exp_q[k]); end
      tick();
    end
    #1;
    total++; if (vld3 !== 1'b0 || cnt3 !== 2'd0) begin bad++; $display("FAIL bp_empty got=%b/%0d exp=0/0", vld3, cnt3); end
  endtask

  task automatic test_full_simul();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'd5; tick();
    in_data = 16'd6; tick();
    in_valid = 1'b0;
    #1;
    total++; if (cnt2 !== 2'd2 || rdy2 !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=2/0", cnt2, rdy2); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'd7;
    #1;
    total++; if (rdy2 !== 1'b1) begin bad++; $display("FAIL full_passthru_ready got=%b exp=1", rdy2); end
    total++; if (dat2 !== 16'd5) begin bad++; $display("FAIL full_out5 got=%0d exp=5", dat2); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (cnt2 !== 2'd2) begin bad++; $display("FAIL full_count_hold got=%0d exp=2", cnt2); end
    total++; if (dat2 !== 16'd6) begin bad++; $display("FAIL full_out6 got=%0d exp=6", dat2); end
    tick();
    #1;
    total++; if (vld2 !== 1'b1 || dat2 !== 16'd7) begin bad++; $display("FAIL full_out7 got=%b/%0d exp=1/7", vld2, dat2); end
    tick();
    #1;
    total++; if (vld2 !== 1'b0) begin bad++; $display("FAIL full_drained got=%b exp=0", vld2); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = DW'(i); tick();
    end
    flush_i = 1'b1; in_valid = 1'b1; in_data = 16'd9; out_ready = 1'b1;
    tick();
    flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++; if (cnt4 !== 3'd0 || vld4 !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0d/%b exp=0/0", cnt4, vld4); end
    total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", rdy4); end
    in_valid = 1'b1; in_data = 16'd10;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (vld4 !== 1'b1 || dat4 !== 16'd10 || cnt4 !== 3'd1)
      begin bad++; $display("FAIL flush_push10 got=%b/%0d/%0d exp=1/10/1", vld4, dat4, cnt4); end
    tick();
    #1;
    total++; if (vld4 !== 1'b0) begin bad++; $display("FAIL flush_no9 got=%b/%0d exp=0", vld4, dat4); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = DW'(i); tick();
    end
    in_data = 16'd7; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (cnt4 !== 3'd0 || vld4 !== 1'b0 || rdy4 !== 1'b1)
      begin bad++; $display("FAIL midrst_state got=%0d/%b/%b exp=0/0/1", cnt4, vld4, rdy4); end
    out_ready = 1'b1;
    tick();
    #1;
    total++; if (vld4 !== 1'b0) begin bad++; $display("FAIL midrst_stale got=%b/%0d exp=0", vld4, dat4); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd11;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (vld4 !== 1'b1 || dat4 !== 16'd11) begin bad++; $display("FAIL midrst_push got=%b/%0d exp=1/11", vld4, dat4); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure_wrap();
    test_full_simul();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
